// File: rtl/nn_mem_pkg.sv
// Shared types and defaults for the NN-engine SDRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bus width / watchdog defaults, FSM state encoding, round-robin pick.
package nn_mem_pkg;

  localparam int NN_ADDR_W     = 32;
  localparam int NN_DATA_W     = 16;
  localparam int NN_RD_TIMEOUT = 1023;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CMD_ENC  = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE_ENC,
    CMD       = ST_CMD_ENC,
    WAIT_DATA = ST_WAIT_ENC
  } arb_state_t;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 held the previous grant.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    return req1 & (~req0 | ~last_grant);
  endfunction

endpackage

// File: rtl/nn_mem_arbiter_if.sv
// Avalon-MM style request/response bundle (one instance per link).
// Latency: n/a (wires only).
// Backpressure: waitrequest from slave stalls the master's strobes.
// Ports: master drives read_n/write_n/address/writedata/byteenable and
//        receives waitrequest/readdatavalid/readdata; slave is the mirror.
interface nn_mem_arbiter_if
  import nn_mem_pkg::*;
#(
  parameter int ADDR_W = NN_ADDR_W,
  parameter int DATA_W = NN_DATA_W
);

  logic              read_n;
  logic              write_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [1:0]        byteenable;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output read_n, write_n, address, writedata, byteenable,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read_n, write_n, address, writedata, byteenable,
    output waitrequest, readdatavalid, readdata
  );

endinterface

// File: rtl/nn_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM port between two NN engines.
// Latency: grant one cycle after request; waitrequest/readdatavalid pass through combinationally.
// Backpressure: owner sees av waitrequest; non-owner and idle see waitrequest=1.
// Ports: clk, reset_n (sync, active-low); m0/m1 requester links (slave side);
//        av downstream link (master side) plus av_chipselect; owner, busy,
//        timeout_err status.
module nn_mem_arbiter
  import nn_mem_pkg::*;
#(
  parameter int ADDR_W     = NN_ADDR_W,
  parameter int DATA_W     = NN_DATA_W,
  parameter int RD_TIMEOUT = NN_RD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  nn_mem_arbiter_if.slave  m0,
  nn_mem_arbiter_if.slave  m1,
  nn_mem_arbiter_if.master av,
  output logic             av_chipselect,
  output logic             owner,
  output logic             busy,
  output logic             timeout_err
);

  localparam int              WD_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(RD_TIMEOUT);

  arb_state_t      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            timeout_err_q, timeout_err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic              req0, req1, grant;
  logic              own_read_n, own_write_n;
  logic [ADDR_W-1:0] own_address;
  logic [DATA_W-1:0] own_writedata;
  logic [1:0]        own_byteenable;
  logic              own_waitrequest;
  logic              own_readdatavalid;
  logic [DATA_W-1:0] own_readdata;

  assign req0  = ~m0.read_n | ~m0.write_n;
  assign req1  = ~m1.read_n | ~m1.write_n;
  assign grant = rr_pick(req0, req1, last_grant_q);

  // Owner-side view of the requester links, selected by the registered owner.
  assign own_read_n     = owner_q ? m1.read_n     : m0.read_n;
  assign own_write_n    = owner_q ? m1.write_n    : m0.write_n;
  assign own_address    = owner_q ? m1.address    : m0.address;
  assign own_writedata  = owner_q ? m1.writedata  : m0.writedata;
  assign own_byteenable = owner_q ? m1.byteenable : m0.byteenable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_grant_d      = last_grant_q;
    timeout_err_d     = timeout_err_q;
    wd_d              = wd_q;
    av.read_n         = 1'b1;
    av.write_n        = 1'b1;
    av.address        = own_address;
    av.writedata      = own_writedata;
    av.byteenable     = own_byteenable;
    av_chipselect     = 1'b0;
    own_waitrequest   = 1'b1;
    own_readdatavalid = 1'b0;
    own_readdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = CMD;
        end
      end

      CMD: begin
        // A read strobe masks a simultaneous write strobe.
        av.read_n       = own_read_n;
        av.write_n      = own_read_n ? own_write_n : 1'b1;
        av_chipselect   = 1'b1;
        own_waitrequest = av.waitrequest;
        if (own_read_n && own_write_n) begin
          state_d = IDLE;
        end else if (!av.waitrequest) begin
          if (!own_read_n) begin
            state_d = WAIT_DATA;
            wd_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WAIT_DATA: begin
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        if (av.readdatavalid) begin
          own_readdatavalid = 1'b1;
          own_readdata      = av.readdata;
          state_d           = IDLE;
        end else if (wd_q == WD_MAX) begin
          // Lost response: release the engine with a zero word.
          own_readdatavalid = 1'b1;
          timeout_err_d     = 1'b1;
          state_d           = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0.waitrequest   = owner_q ? 1'b1 : own_waitrequest;
  assign m1.waitrequest   = owner_q ? own_waitrequest : 1'b1;
  assign m0.readdatavalid = owner_q ? 1'b0 : own_readdatavalid;
  assign m1.readdatavalid = owner_q ? own_readdatavalid : 1'b0;
  assign m0.readdata      = owner_q ? '0 : own_readdata;
  assign m1.readdata      = owner_q ? own_readdata : '0;

  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nn_mem_arbiter.sv
module tb_nn_mem_arbiter;

  localparam int TB_RD_TIMEOUT = 1023;

  logic clk = 1'b0;
  logic reset_n;
  logic av_chipselect, owner, busy, timeout_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nn_mem_arbiter_if #(.ADDR_W(32), .DATA_W(16)) m0_if ();
  nn_mem_arbiter_if #(.ADDR_W(32), .DATA_W(16)) m1_if ();
  nn_mem_arbiter_if #(.ADDR_W(32), .DATA_W(16)) av_if ();

  nn_mem_arbiter #(.ADDR_W(32), .DATA_W(16), .RD_TIMEOUT(TB_RD_TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m0           (m0_if),
    .m1           (m1_if),
    .av           (av_if),
    .av_chipselect(av_chipselect),
    .owner        (owner),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.read_n = 1'b1; m0_if.write_n = 1'b1; m0_if.address = '0;
    m0_if.writedata = '0; m0_if.byteenable = 2'b11;
    m1_if.read_n = 1'b1; m1_if.write_n = 1'b1; m1_if.address = '0;
    m1_if.writedata = '0; m1_if.byteenable = 2'b11;
    av_if.waitrequest = 1'b0; av_if.readdatavalid = 1'b0; av_if.readdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if (av_if.read_n !== 1'b1) begin n_bad++; $display("FAIL reset_av_read_n got=%b exp=1", av_if.read_n); end
    n_cmp++; if (av_if.write_n !== 1'b1) begin n_bad++; $display("FAIL reset_av_write_n got=%b exp=1", av_if.write_n); end
    n_cmp++; if (av_chipselect !== 1'b0) begin n_bad++; $display("FAIL reset_chipselect got=%b exp=0", av_chipselect); end
    n_cmp++; if (m0_if.waitrequest !== 1'b1) begin n_bad++; $display("FAIL reset_m0_wait got=%b exp=1", m0_if.waitrequest); end
    n_cmp++; if (m1_if.waitrequest !== 1'b1) begin n_bad++; $display("FAIL reset_m1_wait got=%b exp=1", m1_if.waitrequest); end
    n_cmp++; if (m0_if.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_m0_rdv got=%b exp=0", m0_if.readdatavalid); end
    n_cmp++; if (m1_if.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_m1_rdv got=%b exp=0", m1_if.readdatavalid); end
    n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    reset_n = 1'b1;
    next_cycle();
  endtask

  // m0 reads 0x28292, memory answers in the third WAIT_DATA cycle.
  task automatic test_single_read();
    int rdv_cnt = 0;
    idle_inputs();
    m0_if.address = 32'h0002_8292;
    for (int c = 0; c < 6; c++) begin
      m0_if.read_n        = (c < 2) ? 1'b0 : 1'b1;
      av_if.readdatavalid = (c == 4);
      av_if.readdata      = (c == 4) ? 16'h0101 : 16'h5A5A;
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (av_if.read_n !== 1'b1) begin n_bad++; $display("FAIL rd_no_early_strobe got=%b exp=1", av_if.read_n); end
      end
      if (c == 1) begin
        n_cmp++; if (av_if.read_n !== 1'b0) begin n_bad++; $display("FAIL rd_grant_strobe got=%b exp=0", av_if.read_n); end
        n_cmp++; if (av_if.address !== 32'h0002_8292) begin n_bad++; $display("FAIL rd_address got=%h exp=00028292", av_if.address); end
        n_cmp++; if (av_chipselect !== 1'b1) begin n_bad++; $display("FAIL rd_chipselect got=%b exp=1", av_chipselect); end
        n_cmp++; if (m0_if.waitrequest !== 1'b0) begin n_bad++; $display("FAIL rd_m0_wait got=%b exp=0", m0_if.waitrequest); end
      end
      if (m0_if.readdatavalid === 1'b1) begin
        rdv_cnt++;
        n_cmp++; if (m0_if.readdata !== 16'h0101) begin n_bad++; $display("FAIL rd_data got=%h exp=0101", m0_if.readdata); end
        n_cmp++; if (c != 4) begin n_bad++; $display("FAIL rd_rdv_cycle got=%0d exp=4", c); end
      end
      n_cmp++; if (m1_if.waitrequest !== 1'b1) begin n_bad++; $display("FAIL rd_m1_wait cyc=%0d got=%b exp=1", c, m1_if.waitrequest); end
      n_cmp++; if (m1_if.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL rd_m1_rdv cyc=%0d got=%b exp=0", c, m1_if.readdatavalid); end
      next_cycle();
    end
    n_cmp++; if (rdv_cnt != 1) begin n_bad++; $display("FAIL rd_rdv_count got=%0d exp=1", rdv_cnt); end
    idle_inputs();
  endtask

  // m1 write held off by five cycles of downstream waitrequest.
  task automatic test_write_stall();
    int   acc = 0;
    logic wr_done = 1'b0;
    idle_inputs();
    m1_if.address    = 32'h0001_32A2;
    m1_if.writedata  = 16'hFFF3;
    m1_if.byteenable = 2'b01;
    for (int c = 0; c < 9; c++) begin
      m1_if.write_n     = wr_done;
      av_if.waitrequest = (c <= 5);
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        n_cmp++; if (m1_if.waitrequest !== av_if.waitrequest) begin n_bad++; $display("FAIL wr_mirror cyc=%0d got=%b exp=%b", c, m1_if.waitrequest, av_if.waitrequest); end
        n_cmp++; if (av_if.write_n !== 1'b0) begin n_bad++; $display("FAIL wr_strobe cyc=%0d got=%b exp=0", c, av_if.write_n); end
        n_cmp++; if (av_if.writedata !== 16'hFFF3 || av_if.address !== 32'h0001_32A2 || av_if.byteenable !== 2'b01) begin
          n_bad++; $display("FAIL wr_bus cyc=%0d got=%h/%h/%b exp=000132a2/fff3/01", c, av_if.address, av_if.writedata, av_if.byteenable);
        end
      end
      if (c == 0) begin
        n_cmp++; if (m1_if.waitrequest !== 1'b1) begin n_bad++; $display("FAIL wr_idle_wait got=%b exp=1", m1_if.waitrequest); end
      end
      if (c == 7) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_back_idle got=%b exp=0", busy); end
      end
      n_cmp++; if (m0_if.waitrequest !== 1'b1) begin n_bad++; $display("FAIL wr_m0_wait cyc=%0d got=%b exp=1", c, m0_if.waitrequest); end
      if (av_chipselect && !av_if.write_n && !av_if.waitrequest) acc++;
      if (!m1_if.waitrequest) wr_done = 1'b1;
      next_cycle();
    end
    n_cmp++; if (acc != 1) begin n_bad++; $display("FAIL wr_accept_count got=%0d exp=1", acc); end
    idle_inputs();
  endtask

  // Both engines keep random reads/writes queued; grants must alternate
  // and every read must return what the reference memory holds.
  task automatic test_round_robin();
    logic [15:0] ref_mem [16];
    logic [15:0] sl_mem  [16];
    logic        cur_rd [2];
    logic [3:0]  cur_a  [2];
    logic [15:0] cur_wd [2];
    logic        phase  [2];
    logic [15:0] exp_rd [2];
    logic        wq [2];
    logic        rv [2];
    logic [15:0] rd [2];
    logic [3:0]  sl_a = '0;
    logic        exp_id = 1'b0;
    int          lat = -1;
    int          grants = 0;
    int          cyc = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'(i * 16'h1111 + 7);
      sl_mem[i]  = ref_mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      phase[i]  = 1'b0;
      exp_rd[i] = '0;
      cur_rd[i] = 1'($urandom_range(0, 1));
      cur_a[i]  = 4'($urandom_range(0, 15));
      cur_wd[i] = 16'($urandom);
    end
    idle_inputs();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    while (grants < 16 && cyc < 800) begin
      m0_if.read_n    = !(!phase[0] && cur_rd[0]);
      m0_if.write_n   = !(!phase[0] && !cur_rd[0]);
      m0_if.address   = {15'd0, 1'b0, 12'd0, cur_a[0]};
      m0_if.writedata = cur_wd[0];
      m1_if.read_n    = !(!phase[1] && cur_rd[1]);
      m1_if.write_n   = !(!phase[1] && !cur_rd[1]);
      m1_if.address   = {15'd0, 1'b1, 12'd0, cur_a[1]};
      m1_if.writedata = cur_wd[1];
      av_if.waitrequest   = ($urandom_range(0, 2) == 0);
      av_if.readdatavalid = (lat == 0);
      av_if.readdata      = (lat == 0) ? sl_mem[sl_a] : 16'($urandom);
      @(negedge clk);
      if (lat == 0) lat = -1;
      else if (lat > 0) lat--;
      if (av_chipselect && (!av_if.read_n || !av_if.write_n) && !av_if.waitrequest) begin
        n_cmp++; if (av_if.address[16] !== exp_id) begin n_bad++; $display("FAIL rr_grant_order n=%0d got=%b exp=%b", grants, av_if.address[16], exp_id); end
        n_cmp++; if (owner !== exp_id) begin n_bad++; $display("FAIL rr_owner n=%0d got=%b exp=%b", grants, owner, exp_id); end
        exp_id = ~exp_id;
        grants++;
        if (!av_if.read_n) begin
          sl_a = av_if.address[3:0];
          lat  = $urandom_range(0, 3);
        end else begin
          sl_mem[av_if.address[3:0]] = av_if.writedata;
        end
      end
      wq[0] = m0_if.waitrequest; rv[0] = m0_if.readdatavalid; rd[0] = m0_if.readdata;
      wq[1] = m1_if.waitrequest; rv[1] = m1_if.readdatavalid; rd[1] = m1_if.readdata;
      for (int i = 0; i < 2; i++) begin
        if (!phase[i]) begin
          if (rv[i]) begin n_cmp++; n_bad++; $display("FAIL rr_unexpected_rdv req=%0d got=1 exp=0", i); end
          if (!wq[i]) begin
            if (cur_rd[i]) begin
              phase[i]  = 1'b1;
              exp_rd[i] = ref_mem[cur_a[i]];
            end else begin
              ref_mem[cur_a[i]] = cur_wd[i];
              cur_rd[i] = 1'($urandom_range(0, 1));
              cur_a[i]  = 4'($urandom_range(0, 15));
              cur_wd[i] = 16'($urandom);
            end
          end
        end else if (rv[i]) begin
          n_cmp++; if (rd[i] !== exp_rd[i]) begin n_bad++; $display("FAIL rr_read_data req=%0d got=%h exp=%h", i, rd[i], exp_rd[i]); end
          phase[i]  = 1'b0;
          cur_rd[i] = 1'($urandom_range(0, 1));
          cur_a[i]  = 4'($urandom_range(0, 15));
          cur_wd[i] = 16'($urandom);
        end
      end
      next_cycle();
      cyc++;
    end
    n_cmp++; if (grants < 16) begin n_bad++; $display("FAIL rr_budget got=%0d exp=16 grants", grants); end
    idle_inputs();
  endtask

  // Read accepted, response never comes.
  task automatic test_watchdog();
    int          pulse_k = -1;
    logic [15:0] pulse_d = 16'hDEAD;
    idle_inputs();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m0_if.read_n   = 1'b0;
    m0_if.address  = 32'h0000_1000;
    av_if.readdata = 16'hA5A5;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (m0_if.waitrequest !== 1'b0) begin n_bad++; $display("FAIL wd_accept got=%b exp=0", m0_if.waitrequest); end
    next_cycle();
    m0_if.read_n = 1'b1;
    for (int k = 0; k < 1100 && pulse_k < 0; k++) begin
      @(negedge clk);
      if (m0_if.readdatavalid === 1'b1) begin
        pulse_k = k;
        pulse_d = m0_if.readdata;
      end
      next_cycle();
    end
    n_cmp++; if (pulse_k != TB_RD_TIMEOUT) begin n_bad++; $display("FAIL wd_pulse_cycle got=%0d exp=%0d", pulse_k, TB_RD_TIMEOUT); end
    n_cmp++; if (pulse_d !== 16'h0000) begin n_bad++; $display("FAIL wd_pulse_data got=%h exp=0000", pulse_d); end
    @(negedge clk);
    n_cmp++; if (m0_if.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL wd_single_pulse got=%b exp=0", m0_if.readdatavalid); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL wd_err_set got=%b exp=1", timeout_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_back_idle got=%b exp=0", busy); end
    for (int k = 0; k < 10; k++) next_cycle();
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL wd_err_sticky got=%b exp=1", timeout_err); end
    next_cycle();
    idle_inputs();
  endtask

  // Stray responses in IDLE, then reset in the middle of a read.
  task automatic test_stray_reset();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      av_if.readdatavalid = 1'b1;
      av_if.readdata      = 16'hBEEF;
      @(negedge clk);
      n_cmp++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
        n_bad++; $display("FAIL stray_rdv got=%b%b exp=00", m0_if.readdatavalid, m1_if.readdatavalid);
      end
      n_cmp++; if (m0_if.readdata !== 16'h0 || m1_if.readdata !== 16'h0) begin
        n_bad++; $display("FAIL stray_data got=%h/%h exp=0000/0000", m0_if.readdata, m1_if.readdata);
      end
      next_cycle();
    end
    av_if.readdatavalid = 1'b0;
    m1_if.read_n  = 1'b0;
    m1_if.address = 32'h0000_0044;
    next_cycle();
    next_cycle();
    m1_if.read_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || owner !== 1'b1) begin n_bad++; $display("FAIL rst_in_wait got=%b/%b exp=1/1", busy, owner); end
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    av_if.readdatavalid = 1'b1;
    av_if.readdata      = 16'h1234;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner got=%b exp=0", owner); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    n_cmp++; if (av_if.read_n !== 1'b1 || av_if.write_n !== 1'b1 || av_chipselect !== 1'b0) begin
      n_bad++; $display("FAIL rst_av got=%b%b%b exp=110", av_if.read_n, av_if.write_n, av_chipselect);
    end
    n_cmp++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait got=%b%b exp=11", m0_if.waitrequest, m1_if.waitrequest);
    end
    n_cmp++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_late_rdv got=%b%b exp=00", m0_if.readdatavalid, m1_if.readdatavalid);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (m1_if.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL rst_late_rdv2 got=%b exp=0", m1_if.readdatavalid); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_stall();
    test_round_robin();
    test_watchdog();
    test_stray_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_mem_arbiter.md
# nn_mem_arbiter

- Shares the single 16-bit Avalon-MM master port to SDRAM between two NN layer engines (requester 0 = layer-1 engine, requester 1 = layer-2 engine).
- Uses fair round-robin arbitration.
- Locks the port to the owner from command issue until a write is accepted or read data returns.
- A read-latency watchdog guarantees no engine hangs on a lost `readdatavalid`.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 16, data width
- RD_TIMEOUT, 1023, max cycles waiting for `readdatavalid` after read accept

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- m0_read_n, m1_read_n  in  1  requester read strobe, active-low
- m0_write_n, m1_write_n  in  1  requester write strobe, active-low
- m0_address, m1_address  in  ADDR_W  requester byte address
- m0_writedata, m1_writedata  in  DATA_W  requester write data
- m0_byteenable, m1_byteenable  in  2  requester byte enables
- m0_waitrequest, m1_waitrequest  out  1  stall to requester
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid to requester
- m0_readdata, m1_readdata  out  DATA_W  read data to requester
- av_read_n, av_write_n  out  1  downstream strobes, active-low
- av_address  out  ADDR_W  downstream address
- av_writedata  out  DATA_W  downstream write data
- av_byteenable  out  2  downstream byte enables
- av_chipselect  out  1  downstream chipselect
- av_waitrequest, av_readdatavalid  in  1  downstream handshake
- av_readdata  in  DATA_W  downstream read data
- owner  out  1  current or last grant id
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- A requester `i` is requesting when `!mi_read_n || !mi_write_n`. If both strobes are low, the read is forwarded and the write is ignored.
- **States:** IDLE, CMD, WAIT_DATA.
- **IDLE**
  - If any request, register `owner` and go to CMD.
  - Both requesting: grant the requester that is not `last_grant`.
  - On grant, update `last_grant <= owner`. Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- **CMD**
  - `av_*` carry the owner's signals; `av_chipselect = 1`; `m_owner_waitrequest = av_waitrequest`.
  - Read accepted (`!av_waitrequest`): go to WAIT_DATA and clear the watchdog.
  - Write accepted: go to IDLE.
  - Owner request drops before accept: go to IDLE with no transaction.
- **WAIT_DATA**
  - `av` strobes deasserted; watchdog increments.
  - On `av_readdatavalid`: `m_owner_readdatavalid = 1` and `m_owner_readdata = av_readdata` in the same cycle; go to IDLE.
  - On watchdog == RD_TIMEOUT: pulse `m_owner_readdatavalid` with readdata 16'h0000, set `timeout_err`, go to IDLE.
- **Non-owner / IDLE:** `waitrequest = 1`, `readdatavalid = 0`.
- **Stray inputs:** `av_readdatavalid` outside WAIT_DATA is ignored. `readdata` to the non-owner is 0.
- **Watchdog:** 10-bit counter, saturating; width = clog2(RD_TIMEOUT+1).
- **Errors:** `timeout_err` clears only on reset.

## Timing
- Grant latency: request seen in IDLE at cycle N; `av` strobe low at N+1.
- Minimum occupancy:
  - Write: 2 cycles (IDLE, CMD).
  - Read: 3 cycles plus memory latency.
- Back-to-back: a new grant is evaluated in the IDLE cycle that follows completion. The other requester is granted there if it is waiting.
- Output paths from `av_*` / `m*_*`:
  - Combinational muxes driven by registered `state`/`owner`.
  - `waitrequest` and `readdatavalid` are pure pass-through, with no added latency.
- Reset values:
  - state IDLE; `av_read_n = av_write_n = 1`; `av_chipselect = 0`.
  - `m*_waitrequest = 1`; `m*_readdatavalid = 0`.
  - `owner = 0`; `busy = 0`; `timeout_err = 0`; watchdog 0.
- Reset mid-transaction: abandons the transaction immediately. A late `av_readdatavalid` after reset is ignored.

## Structure
- Package `nn_mem_pkg` holds:
  - State encoding localparams (IDLE=0, CMD=1, WAIT_DATA=2).
  - `DATA_W`/`ADDR_W` defaults.
  - `RD_TIMEOUT` default.
- Single flat module; no sub-module. The round-robin pick is two gates.

## Test plan
- Single read:
  - Stimulus: m0 read 0x28292; av_waitrequest low; readdatavalid 3 cycles later with 16'h0101.
  - Required: `m0_readdatavalid` for exactly 1 cycle with 16'h0101; m1 sees waitrequest = 1 throughout.
- Simultaneous requests from reset:
  - Stimulus: m0 and m1 each issue repeated reads.
  - Required: grants alternate 0,1,0,1; neither requester is granted twice in a row while the other waits.
- Write with stall:
  - Stimulus: m1 write 0x132A2 with data 16'hFFF3; av_waitrequest held high 5 cycles.
  - Required: `m1_waitrequest` mirrors it; exactly one write accepted; then IDLE.
- Watchdog:
  - Stimulus: read accepted, no readdatavalid.
  - Required: after 1023 cycles, `m0_readdatavalid = 1` with data 0; `timeout_err` = 1 and stays set.
- Stray and reset:
  - Stimulus: av_readdatavalid pulses in IDLE; then reset asserted during WAIT_DATA.
  - Required: stray pulse produces no `m*_readdatavalid`; all outputs reach reset values the next cycle.
